// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache with miss FSM.
// Optional DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_ctrl #(
  parameter int LINES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 13 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMP   = 2'd1,
    S_WB    = 2'd2,
    S_ALLOC = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [15:1]        addr_q;
  logic [15:0]        wdata_q;
  logic               is_wr_q;
  logic               refill_q, refill_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [15:0]        dout_q;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [15:0]        data_mem [LINES*4];

  logic [IDX_W-1:0]   idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic [1:0]         off_s;
  logic [IDX_W+1:0]   word_s;
  logic [IDX_W+1:0]   xfer_word_s;
  logic [TAG_W-1:0]   line_tag_s;
  logic               hit_s;
  logic               latch_s, load_s, store_s, fill_s, fill_done_s;

  assign idx_s       = addr_q[IDX_W+2:3];
  assign tag_s       = addr_q[15:IDX_W+3];
  assign off_s       = addr_q[2:1];
  assign word_s      = {idx_s, off_s};
  assign xfer_word_s = {idx_s, cnt_q};
  assign line_tag_s  = tag_mem[idx_s];
  assign hit_s       = valid_q[idx_s] && (line_tag_s == tag_s);
  assign DataOut     = dout_q;

  // Next-state and strobe decode for the request/miss sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    refill_d    = refill_q;
    err         = 1'b0;
    Done        = 1'b0;
    CacheHit    = 1'b0;
    Stall       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = 16'h0000;
    mem_wdata   = 16'h0000;
    latch_s     = 1'b0;
    load_s      = 1'b0;
    store_s     = 1'b0;
    fill_s      = 1'b0;
    fill_done_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Rd | Wr) begin
          if ((Rd & Wr) | Addr[0]) begin
            err = 1'b1;
          end else begin
            latch_s  = 1'b1;
            Stall    = 1'b1;
            refill_d = 1'b0;
            state_d  = S_CMP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMP: begin
        if (hit_s) begin
          Done     = 1'b1;
          CacheHit = ~refill_q;
          store_s  = is_wr_q;
          load_s   = ~is_wr_q;
          state_d  = S_IDLE;
        end else begin
          Stall   = 1'b1;
          cnt_d   = 2'd0;
          state_d = dirty_q[idx_s] ? S_WB : S_ALLOC;
        end
      end
      S_WB: begin
        Stall     = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {line_tag_s, idx_s, cnt_q, 1'b0};
        mem_wdata = data_mem[xfer_word_s];
        if (mem_ack) begin
          cnt_d   = cnt_q + 2'd1;
          state_d = (cnt_q == 2'd3) ? S_ALLOC : S_WB;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_ALLOC: begin
        Stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {tag_s, idx_s, cnt_q, 1'b0};
        if (mem_ack) begin
          fill_s = 1'b1;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            fill_done_s = 1'b1;
            refill_d    = 1'b1;
            state_d     = S_CMP;
          end else begin
            state_d = S_ALLOC;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, latched request, line status bits and held load data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 15'd0;
      wdata_q  <= 16'h0000;
      is_wr_q  <= 1'b0;
      refill_q <= 1'b0;
      cnt_q    <= 2'd0;
      dout_q   <= 16'h0000;
      valid_q  <= {LINES{1'b0}};
      dirty_q  <= {LINES{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      refill_q <= refill_d;
      if (latch_s) begin
        addr_q  <= Addr[15:1];
        wdata_q <= DataIn;
        is_wr_q <= Wr;
      end
      if (load_s) dout_q <= data_mem[word_s];
      if (store_s) dirty_q[idx_s] <= 1'b1;
      if (fill_done_s) begin
        valid_q[idx_s] <= 1'b1;
        dirty_q[idx_s] <= 1'b0;
      end
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (store_s) data_mem[word_s] <= wdata_q;
    if (fill_s) data_mem[xfer_word_s] <= mem_rdata;
    if (fill_done_s) tag_mem[idx_s] <= tag_s;
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_q, miss_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // Saturating statistics: hits on hit Done, misses on leaving CMP for a refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= 16'h0000;
      miss_q <= 16'h0000;
    end else begin
      if (Done && CacheHit && (hit_q != 16'hFFFF)) hit_q <= hit_q + 16'd1;
      if ((state_q == S_CMP) && !hit_s && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level cache/memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
  logic        Rd, Wr, Done, Stall, CacheHit, err, mem_rd, mem_wr, mem_ack;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] bmem    [32768];
  logic [15:0] ref_mem [32768];
  logic        m_valid [32];
  logic        m_dirty [32];
  logic [7:0]  m_tag   [32];
  logic [15:0] m_data  [32][4];
  logic [15:0] m_dout;
  int          m_hits, m_misses;
  txn_t        got_q[$];
  int          delay_min = 1;
  int          delay_max = 1;
  bit          force_ack = 1'b0;
  int          last_lat;
  logic        last_hit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_dout   = 16'h0000;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"}, DataOut, 16'h0000);
    chk({tag, "_done"}, Done, 1'b0);
    chk({tag, "_stall"}, Stall, 1'b0);
    chk({tag, "_hit"}, CacheHit, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_mrd"}, mem_rd, 1'b0);
    chk({tag, "_mwr"}, mem_wr, 1'b0);
    chk({tag, "_maddr"}, mem_addr, 16'h0000);
    chk({tag, "_mwdata"}, mem_wdata, 16'h0000);
  endtask

  // Backing memory: acks each strobe after a random 1..N cycle wait
  initial begin : responder
    int waited;
    int dly;
    waited    = 0;
    dly       = 1;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (force_ack) begin
        mem_ack   = 1'b1;
        force_ack = 1'b0;
      end else if ((mem_rd || mem_wr) && !rst) begin
        if (waited >= dly) begin
          mem_ack = 1'b1;
          if (mem_wr) begin
            bmem[mem_addr[15:1]] = mem_wdata;
            got_q.push_back({1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = bmem[mem_addr[15:1]];
            got_q.push_back({1'b0, mem_addr, mem_rdata});
          end
          waited = 0;
          dly    = $urandom_range(delay_max, delay_min);
        end else begin
          mem_ack = 1'b0;
          waited++;
        end
      end else begin
        mem_ack = 1'b0;
        waited  = 0;
      end
    end
  end

  task automatic noise();
    Rd     = 1'($urandom);
    Wr     = 1'($urandom);
    Addr   = 16'($urandom);
    DataIn = 16'($urandom);
  endtask

  // Called at posedge+2 with the DUT idle; returns at posedge+2 with the DUT idle again.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    logic       legal, hit, seen;
    logic [4:0] idx;
    logic [7:0] tg;
    logic [1:0] off, kk;
    logic [15:0] wa;
    txn_t       exp_q[$];
    int         strobes;
    got_q.delete();
    legal  = (rd ^ wr) && !a[0];
    Rd     = rd;
    Wr     = wr;
    Addr   = a;
    DataIn = d;
    @(negedge clk);
    if (!legal) begin
      chk("err_flag", err, 1'b1);
      chk("err_stall", Stall, 1'b0);
      chk("err_strobe", mem_rd | mem_wr, 1'b0);
      @(posedge clk);
      #2;
      Rd = 1'b0;
      Wr = 1'b0;
      @(negedge clk);
      chk("err_no_done", Done, 1'b0);
      chk("err_still_idle", Stall, 1'b0);
      @(posedge clk);
      #2;
      return;
    end
    chk("req_err", err, 1'b0);
    chk("req_stall", Stall, 1'b1);

    idx = a[7:3];
    tg  = a[15:8];
    off = a[2:1];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (!hit) begin
      if (m_dirty[idx]) begin
        for (int k = 0; k < 4; k++) begin
          kk = 2'(k);
          wa = {m_tag[idx], idx, kk, 1'b0};
          exp_q.push_back({1'b1, wa, m_data[idx][k]});
          ref_mem[wa[15:1]] = m_data[idx][k];
        end
      end
      for (int k = 0; k < 4; k++) begin
        kk = 2'(k);
        wa = {tg, idx, kk, 1'b0};
        m_data[idx][k] = ref_mem[wa[15:1]];
        exp_q.push_back({1'b0, wa, m_data[idx][k]});
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_misses++;
    end else begin
      m_hits++;
    end
    if (wr) begin
      m_data[idx][off] = d;
      m_dirty[idx]     = 1'b1;
    end else begin
      m_dout = m_data[idx][off];
    end

    strobes  = 0;
    seen     = 1'b0;
    last_lat = 0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      @(posedge clk);
      #2;
      noise();
      @(negedge clk);
      if (mem_rd && mem_wr) chk("strobe_excl", {mem_rd, mem_wr}, 2'b01);
      if (mem_rd || mem_wr) strobes++;
      if (Done) begin
        seen     = 1'b1;
        last_lat = c;
      end else begin
        chk("busy_stall", Stall, 1'b1);
        if (err) chk("busy_err", err, 1'b0);
        if (CacheHit) chk("busy_hit", CacheHit, 1'b0);
      end
    end
    chk("done_seen", seen, 1'b1);
    last_hit = CacheHit;
    chk("done_stall", Stall, 1'b0);
    chk("done_err", err, 1'b0);
    chk("done_cachehit", CacheHit, hit);
    chk("done_strobe", mem_rd | mem_wr, 1'b0);
    chk("latency", last_lat, hit ? 1 : 2 + strobes);
    chk("txn_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      chk("txn_wr", got_q[k].wr, exp_q[k].wr);
      chk("txn_addr", got_q[k].addr, exp_q[k].addr);
      chk("txn_data", got_q[k].data, exp_q[k].data);
    end
    @(posedge clk);
    #2;
    Rd = 1'b0;
    Wr = 1'b0;
    chk("dataout_hold", DataOut, m_dout);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] a;
    logic        rd;
    int          r;
    bit          found;
    logic [7:0]  tags [4];
    tags[0] = 8'h00; tags[1] = 8'h01; tags[2] = 8'h40; tags[3] = 8'hFF;
    for (int i = 0; i < 32768; i++) begin
      bmem[i]    = 16'($urandom);
      ref_mem[i] = bmem[i];
    end
    bmem[8] = 16'h1234; ref_mem[8] = 16'h1234;
    bmem[9] = 16'h5678; ref_mem[9] = 16'h5678;
    Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Cold load, repeat hit, store hit then conflicting dirty miss
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("s1_dout", DataOut, 16'h1234);
    chk("s1_hit", last_hit, 1'b0);
    chk("s1_lat", last_lat, 10);
    chk("s1_ntx", got_q.size(), 4);
    chk("s1_a0", got_q[0].addr, 16'h0010);
    chk("s1_a3", got_q[3].addr, 16'h0016);
    do_req(1'b1, 1'b0, 16'h0012, 16'h0000);
    chk("s2_dout", DataOut, 16'h5678);
    chk("s2_hit", last_hit, 1'b1);
    chk("s2_lat", last_lat, 1);
    chk("s2_ntx", got_q.size(), 0);
    do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("s3_store_hit", last_hit, 1'b1);
    do_req(1'b1, 1'b0, 16'h0110, 16'h0000);
    chk("s3_ntx", got_q.size(), 8);
    chk("s3_w0", {got_q[0].wr, got_q[0].addr, got_q[0].data}, {1'b1, 16'h0010, 16'hBEEF});
    chk("s3_w1", {got_q[1].wr, got_q[1].addr, got_q[1].data}, {1'b1, 16'h0012, 16'h5678});
    chk("s3_w3a", got_q[3].addr, 16'h0016);
    chk("s3_r0", {got_q[4].wr, got_q[4].addr}, {1'b0, 16'h0110});
    chk("s3_r3", got_q[7].addr, 16'h0116);
    chk("s3_lat", last_lat, 18);
`ifdef DCACHE_STATS_EN
    chk("s6_hits", hit_count, 16'd2);
    chk("s6_miss", miss_count, 16'd2);
`endif

    // Illegal requests are dropped and the next one is still serviced
    do_req(1'b1, 1'b1, 16'h0020, 16'h0000);
    do_req(1'b1, 1'b0, 16'h0011, 16'h0000);
    do_req(1'b1, 1'b0, 16'h0110, 16'h0000);
    chk("s4_next_hit", last_hit, 1'b1);

    // Reset during the second ALLOC word
    got_q.delete();
    Rd = 1'b1; Addr = 16'h0230;
    @(posedge clk);
    #2;
    Rd = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (mem_rd && (mem_addr == 16'h0232)) found = 1'b1;
    end
    chk("s5_alloc_w1", found, 1'b1);
    rst = 1'b1;
    #1;
    chk_all_zero("s5_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("s5_stray_done", Done, 1'b0);
    chk("s5_stray_stall", Stall, 1'b0);
    chk("s5_stray_rd", mem_rd, 1'b0);
    @(posedge clk);
    #2;
    do_req(1'b1, 1'b0, 16'h0230, 16'h0000);
    chk("s5_miss", last_hit, 1'b0);
    chk("s5_ntx", got_q.size(), 4);
    chk("s5_r0", got_q[0].addr, 16'h0230);

    // Randomized traffic over a few tags and indices to provoke hits and conflicts
    delay_max = 3;
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 24);
      a  = 16'($urandom);
      a[15:8] = tags[$urandom_range(0, 3)];
      a[7:5]  = 3'd0;
      a[0]    = (r == 1) ? 1'b1 : 1'b0;
      rd = 1'($urandom);
      if (r == 0) do_req(1'b1, 1'b1, a, 16'($urandom));
      else do_req(rd, ~rd, a, 16'($urandom));
    end
`ifdef DCACHE_STATS_EN
    chk("stats_hits", hit_count, 16'(m_hits));
    chk("stats_miss", miss_count, 16'(m_misses));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
